// File: rtl/param_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : param_shift_sequencer
// Brief    : Universal WIDTH-bit shift register (8 modes) with a multi-cycle
//            "shift by N" command using a Start/Busy/Done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module param_shift_sequencer #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [2:0]         Mode,
    input  logic [WIDTH-1:0]   Parallel_in,
    input  logic               LS_in,
    input  logic               RS_in,
    input  logic               Start,
    input  logic [SHAMT_W-1:0] Shamt,
    output logic [WIDTH-1:0]   Parallel_Output,
    output logic               LS_out,
    output logic               RS_out,
    output logic               Busy,
    output logic               Done
);

    localparam logic [2:0] c_HOLD = 3'b000;
    localparam logic [2:0] c_SR   = 3'b001;
    localparam logic [2:0] c_SL   = 3'b010;
    localparam logic [2:0] c_LOAD = 3'b011;
    localparam logic [2:0] c_ROR  = 3'b100;
    localparam logic [2:0] c_ROL  = 3'b101;
    localparam logic [2:0] c_ASR  = 3'b110;
    localparam logic [2:0] c_CLR  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [WIDTH-1:0]     r_q, w_q_nxt;
    logic [SHAMT_W-1:0]   r_count, w_count_nxt;
    logic [2:0]           r_mode, w_mode_nxt;
    logic                 w_is_shift;

    // One step of the selected operation; serial inputs are always taken live.
    function automatic logic [WIDTH-1:0] f_step(
        input logic [2:0]       mode,
        input logic [WIDTH-1:0] q,
        input logic [WIDTH-1:0] pin,
        input logic             ls,
        input logic             rs
    );
        logic [WIDTH-1:0] v_res;
        case (mode)
            c_HOLD:  v_res = q;
            c_SR:    v_res = {rs, q[WIDTH-1:1]};
            c_SL:    v_res = {q[WIDTH-2:0], ls};
            c_LOAD:  v_res = pin;
            c_ROR:   v_res = {q[0], q[WIDTH-1:1]};
            c_ROL:   v_res = {q[WIDTH-2:0], q[WIDTH-1]};
            c_ASR:   v_res = {q[WIDTH-1], q[WIDTH-1:1]};
            c_CLR:   v_res = '0;
            default: v_res = q;
        endcase
        return v_res;
    endfunction

    assign w_is_shift = (Mode == c_SR) || (Mode == c_SL) || (Mode == c_ROR) ||
                        (Mode == c_ROL) || (Mode == c_ASR);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_IDLE;
            r_q     <= '0;
            r_count <= '0;
            r_mode  <= c_HOLD;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_count <= w_count_nxt;
            r_mode  <= w_mode_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_count_nxt = r_count;
        w_mode_nxt  = r_mode;
        case (r_state)
            S_IDLE: begin
                if (!Start) begin
                    w_q_nxt = f_step(Mode, r_q, Parallel_in, LS_in, RS_in);
                end else if (Shamt == '0) begin
                    w_state_nxt = S_DONE;
                end else if (w_is_shift) begin
                    w_mode_nxt  = Mode;
                    w_count_nxt = Shamt;
                    w_state_nxt = S_RUN;
                end else begin
                    w_q_nxt     = f_step(Mode, r_q, Parallel_in, LS_in, RS_in);
                    w_state_nxt = S_DONE;
                end
            end
            S_RUN: begin
                w_q_nxt     = f_step(r_mode, r_q, Parallel_in, LS_in, RS_in);
                w_count_nxt = r_count - SHAMT_W'(1);
                if (r_count == SHAMT_W'(1)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign Parallel_Output = r_q;
    assign LS_out          = r_q[WIDTH-1];
    assign RS_out          = r_q[0];
    assign Busy            = (r_state == S_RUN);
    assign Done            = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_param_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_shift_sequencer
// Brief    : Directed self-checking bench for param_shift_sequencer (WIDTH=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_param_shift_sequencer;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [2:0] Mode;
    logic [7:0] Parallel_in;
    logic       LS_in, RS_in, Start;
    logic [4:0] Shamt;
    logic [7:0] Parallel_Output;
    logic       LS_out, RS_out, Busy, Done;

    int n_checks = 0;
    int n_pass   = 0;

    param_shift_sequencer #(.WIDTH(8), .SHAMT_W(5)) dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .Mode            (Mode),
        .Parallel_in     (Parallel_in),
        .LS_in           (LS_in),
        .RS_in           (RS_in),
        .Start           (Start),
        .Shamt           (Shamt),
        .Parallel_Output (Parallel_Output),
        .LS_out          (LS_out),
        .RS_out          (RS_out),
        .Busy            (Busy),
        .Done            (Done)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic load(input logic [7:0] v);
        Mode = 3'b011; Parallel_in = v; Start = 1'b0;
        tick();
        Mode = 3'b000;
    endtask

    task automatic test_reset();
        Reset = 1'b0; Mode = 3'b000; Parallel_in = '0; LS_in = 0; RS_in = 0;
        Start = 0; Shamt = '0;
        #3;
        n_checks++;
        if ({Parallel_Output, Busy, Done} !== {8'h00, 1'b0, 1'b0})
            $display("FAIL reset_init: got Q=%h B=%b D=%b want Q=00 B=0 D=0",
                     Parallel_Output, Busy, Done);
        else n_pass++;
        #5; Reset = 1'b1;
        load(8'h3C);
        #2; Reset = 1'b0; #1;
        n_checks++;
        if ({Parallel_Output, Busy, Done} !== {8'h00, 1'b0, 1'b0})
            $display("FAIL reset_async: got Q=%h B=%b D=%b want Q=00 B=0 D=0",
                     Parallel_Output, Busy, Done);
        else n_pass++;
        #1; Reset = 1'b1;
    endtask

    task automatic test_modes();
        load(8'h5A);
        Mode = 3'b001; RS_in = 1'b1; tick();
        n_checks++;
        if ({Parallel_Output, RS_out, LS_out} !== {8'hAD, 1'b1, 1'b1})
            $display("FAIL sr_step: got Q=%h RS=%b LS=%b want Q=AD RS=1 LS=1",
                     Parallel_Output, RS_out, LS_out);
        else n_pass++;
        Mode = 3'b010; LS_in = 1'b0; RS_in = 1'b0; tick();
        n_checks++;
        if ({Parallel_Output, RS_out, LS_out} !== {8'h5A, 1'b0, 1'b0})
            $display("FAIL sl_step: got Q=%h RS=%b LS=%b want Q=5A RS=0 LS=0",
                     Parallel_Output, RS_out, LS_out);
        else n_pass++;
        Mode = 3'b000; tick();
        Mode = 3'b100; tick();
        n_checks++;
        if (Parallel_Output !== 8'h2D)
            $display("FAIL hold_ror: got Q=%h want 2D", Parallel_Output);
        else n_pass++;
        Mode = 3'b101; tick();
        Mode = 3'b101; tick();
        n_checks++;
        if (Parallel_Output !== 8'hB4)
            $display("FAIL rol_step: got Q=%h want B4", Parallel_Output);
        else n_pass++;
        Mode = 3'b110; tick();
        n_checks++;
        if (Parallel_Output !== 8'hDA)
            $display("FAIL asr_step: got Q=%h want DA", Parallel_Output);
        else n_pass++;
        Mode = 3'b111; tick();
        n_checks++;
        if ({Parallel_Output, Busy, Done} !== {8'h00, 1'b0, 1'b0})
            $display("FAIL clear: got Q=%h B=%b D=%b want Q=00 B=0 D=0",
                     Parallel_Output, Busy, Done);
        else n_pass++;
        Mode = 3'b000;
    endtask

    task automatic test_rol_cmd();
        logic [7:0] exp_q [4] = '{8'h81, 8'h03, 8'h06, 8'h0C};
        load(8'h81);
        Mode = 3'b101; Shamt = 5'd3; Start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            Start = 1'b0; Mode = 3'b000;
            n_checks++;
            if ({Parallel_Output, Busy, Done} !== {exp_q[i], (i < 3), (i == 3)})
                $display("FAIL rol_cmd_edge%0d: got Q=%h B=%b D=%b want Q=%h B=%b D=%b",
                         i, Parallel_Output, Busy, Done, exp_q[i], (i < 3), (i == 3));
            else n_pass++;
        end
        tick();
        n_checks++;
        if ({Parallel_Output, Busy, Done} !== {8'h0C, 1'b0, 1'b0})
            $display("FAIL rol_cmd_after: got Q=%h B=%b D=%b want Q=0C B=0 D=0",
                     Parallel_Output, Busy, Done);
        else n_pass++;
    endtask

    task automatic test_asr_cmd(input logic [4:0] n, input logic [7:0] want);
        load(8'h80);
        Mode = 3'b110; Shamt = n; Start = 1'b1;
        tick();
        Start = 1'b0; Mode = 3'b011; Parallel_in = 8'h55;
        repeat (int'(n) - 1) tick();
        n_checks++;
        if ({Busy, Done} !== 2'b10)
            $display("FAIL asr_cmd_busy_n%0d: got B=%b D=%b want B=1 D=0", n, Busy, Done);
        else n_pass++;
        tick();
        n_checks++;
        if ({Parallel_Output, Busy, Done} !== {want, 1'b0, 1'b1})
            $display("FAIL asr_cmd_n%0d: got Q=%h B=%b D=%b want Q=%h B=0 D=1",
                     n, Parallel_Output, Busy, Done, want);
        else n_pass++;
        Mode = 3'b000;
        tick();
    endtask

    task automatic test_shamt_zero();
        load(8'h37);
        Mode = 3'b101; Shamt = 5'd0; Start = 1'b1;
        tick();
        Start = 1'b0; Mode = 3'b000;
        n_checks++;
        if ({Parallel_Output, Busy, Done} !== {8'h37, 1'b0, 1'b1})
            $display("FAIL shamt0: got Q=%h B=%b D=%b want Q=37 B=0 D=1",
                     Parallel_Output, Busy, Done);
        else n_pass++;
        tick();
        n_checks++;
        if ({Parallel_Output, Busy, Done} !== {8'h37, 1'b0, 1'b0})
            $display("FAIL shamt0_after: got Q=%h B=%b D=%b want Q=37 B=0 D=0",
                     Parallel_Output, Busy, Done);
        else n_pass++;
        Mode = 3'b011; Parallel_in = 8'h99; Shamt = 5'd4; Start = 1'b1;
        tick();
        Start = 1'b0; Mode = 3'b000;
        n_checks++;
        if ({Parallel_Output, Busy, Done} !== {8'h99, 1'b0, 1'b1})
            $display("FAIL load_cmd: got Q=%h B=%b D=%b want Q=99 B=0 D=1",
                     Parallel_Output, Busy, Done);
        else n_pass++;
        tick();
    endtask

    task automatic test_back_to_back();
        load(8'h01);
        Mode = 3'b100; Shamt = 5'd2; Start = 1'b1;
        tick();
        Mode = 3'b111; Shamt = 5'd7; Parallel_in = 8'hFF;
        tick();
        n_checks++;
        if ({Parallel_Output, Busy, Done} !== {8'h80, 1'b1, 1'b0})
            $display("FAIL b2b_run: got Q=%h B=%b D=%b want Q=80 B=1 D=0",
                     Parallel_Output, Busy, Done);
        else n_pass++;
        tick();
        n_checks++;
        if ({Parallel_Output, Busy, Done} !== {8'h40, 1'b0, 1'b1})
            $display("FAIL b2b_done: got Q=%h B=%b D=%b want Q=40 B=0 D=1",
                     Parallel_Output, Busy, Done);
        else n_pass++;
        Mode = 3'b101; Shamt = 5'd1;
        tick();
        n_checks++;
        if ({Parallel_Output, Busy, Done} !== {8'h40, 1'b0, 1'b0})
            $display("FAIL b2b_single_done: got Q=%h B=%b D=%b want Q=40 B=0 D=0",
                     Parallel_Output, Busy, Done);
        else n_pass++;
        tick();
        Start = 1'b0; Mode = 3'b000;
        n_checks++;
        if ({Parallel_Output, Busy, Done} !== {8'h40, 1'b1, 1'b0})
            $display("FAIL b2b_restart: got Q=%h B=%b D=%b want Q=40 B=1 D=0",
                     Parallel_Output, Busy, Done);
        else n_pass++;
        tick();
        n_checks++;
        if ({Parallel_Output, Busy, Done} !== {8'h80, 1'b0, 1'b1})
            $display("FAIL b2b_second: got Q=%h B=%b D=%b want Q=80 B=0 D=1",
                     Parallel_Output, Busy, Done);
        else n_pass++;
        tick();
    endtask

    task automatic test_reset_run();
        load(8'h0F);
        Mode = 3'b100; Shamt = 5'd5; Start = 1'b1;
        tick();
        Start = 1'b0; Mode = 3'b000;
        tick(); tick();
        n_checks++;
        if ({Parallel_Output, Busy} !== {8'hC3, 1'b1})
            $display("FAIL ror_mid: got Q=%h B=%b want Q=C3 B=1", Parallel_Output, Busy);
        else n_pass++;
        #2; Reset = 1'b0; #1;
        n_checks++;
        if ({Parallel_Output, Busy, Done} !== {8'h00, 1'b0, 1'b0})
            $display("FAIL abort: got Q=%h B=%b D=%b want Q=00 B=0 D=0",
                     Parallel_Output, Busy, Done);
        else n_pass++;
        tick(); tick(); tick();
        n_checks++;
        if ({Parallel_Output, Busy, Done} !== {8'h00, 1'b0, 1'b0})
            $display("FAIL abort_hold: got Q=%h B=%b D=%b want Q=00 B=0 D=0",
                     Parallel_Output, Busy, Done);
        else n_pass++;
        #3; Reset = 1'b1;
        load(8'h12);
        Mode = 3'b010; Shamt = 5'd2; Start = 1'b1; LS_in = 1'b1;
        tick();
        Start = 1'b0; Mode = 3'b000;
        tick();
        LS_in = 1'b0;
        tick();
        n_checks++;
        if ({Parallel_Output, Busy, Done} !== {8'h4A, 1'b0, 1'b1})
            $display("FAIL post_reset_cmd: got Q=%h B=%b D=%b want Q=4A B=0 D=1",
                     Parallel_Output, Busy, Done);
        else n_pass++;
        tick();
    endtask

    initial begin
        test_reset();
        test_modes();
        test_rol_cmd();
        test_asr_cmd(5'd2, 8'hE0);
        test_asr_cmd(5'd20, 8'hFF);
        test_shamt_zero();
        test_back_to_back();
        test_reset_run();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
